// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch predictor.
//   INDEX_W_DEF / TAG_W_DEF : default BTB geometry (32 entries, 25-bit tags)
//   TAG_STORE_W             : stored tag field width, wide enough for any INDEX_W
//   ctr_e                   : 2-bit saturating direction counter states
//   entry_t                 : one BTB entry (valid, tag, target, counter)
package bp_pkg;

   localparam int INDEX_W_DEF = 5;
   localparam int TAG_W_DEF   = 32 - INDEX_W_DEF - 2;

   // The entry struct cannot follow a per-instance TAG_W, so tags are kept
   // zero-extended in a field sized for the widest possible tag (INDEX_W=0).
   localparam int TAG_STORE_W = 30;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_e;

   typedef struct packed {
      logic                   valid;
      logic [TAG_STORE_W-1:0] tag;
      logic [31:0]            target;
      ctr_e                   ctr;
   } entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating up/down counter, next-state only (no storage).
//   ctr  : current counter state
//   up   : 1 = count toward strongly taken, 0 = toward strongly not-taken
//   next : saturated next state
module sat_counter2
   import bp_pkg::*;
(
   input  ctr_e ctr,
   input  logic up,
   output ctr_e next
);

   always_comb begin
      next = ctr;
      unique case (ctr)
         SNT: next = up ? WNT : SNT;
         WNT: next = up ? WT  : SNT;
         WT:  next = up ? ST  : WNT;
         ST:  next = up ? ST  : WT;
         default: next = ctr;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, mispredict detection and
// statistics counters.
//   i_clk, i_reset            : rising-edge clock, async active-high reset
//   i_pc                      : fetch PC looked up combinationally
//   o_pred_taken, o_pred_pc   : prediction for i_pc
//   i_upd_*                   : resolved branch from EX (pc, outcome, target,
//                               and the prediction that was issued for it)
//   o_mispredict, o_redirect_pc : combinational resolve result
//   o_br_count, o_miss_count  : saturating counts of updates / mispredicts
module branch_predictor
   import bp_pkg::*;
#(
   parameter int INDEX_W = INDEX_W_DEF,
   parameter int TAG_W   = 32 - INDEX_W - 2
)(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_pc,
   output logic        o_pred_taken,
   output logic [31:0] o_pred_pc,
   input  logic        i_upd_valid,
   input  logic [31:0] i_upd_pc,
   input  logic        i_upd_taken,
   input  logic [31:0] i_upd_target,
   input  logic        i_upd_pred_taken,
   input  logic [31:0] i_upd_pred_pc,
   output logic        o_mispredict,
   output logic [31:0] o_redirect_pc,
   output logic [31:0] o_br_count,
   output logic [31:0] o_miss_count
);

   localparam int ENTRIES = 1 << INDEX_W;

   entry_t             table_q [ENTRIES];

   logic [INDEX_W-1:0] look_idx;
   logic [TAG_W-1:0]   look_tag;
   entry_t             look_entry;
   logic               look_hit;

   logic [INDEX_W-1:0] upd_idx;
   logic [TAG_W-1:0]   upd_tag;
   entry_t             upd_entry;
   logic               upd_hit;
   ctr_e               ctr_next;

   // Fetch-side lookup reads the registered table directly, so a same-cycle
   // update is only visible from the following cycle.
   assign look_idx   = i_pc[INDEX_W+1:2];
   assign look_tag   = i_pc[31:INDEX_W+2];
   assign look_entry = table_q[look_idx];
   assign look_hit   = look_entry.valid && (look_entry.tag == TAG_STORE_W'(look_tag));

   assign o_pred_taken = look_hit && look_entry.ctr[1];
   assign o_pred_pc    = o_pred_taken ? look_entry.target : i_pc + 32'd4;

   // Resolve: a wrong direction always mispredicts; a correct taken
   // prediction still mispredicts if it pointed at the wrong target.
   assign o_mispredict  = i_upd_valid &&
                          ((i_upd_taken != i_upd_pred_taken) ||
                           (i_upd_taken && (i_upd_target != i_upd_pred_pc)));
   assign o_redirect_pc = i_upd_taken ? i_upd_target : i_upd_pc + 32'd4;

   assign upd_idx   = i_upd_pc[INDEX_W+1:2];
   assign upd_tag   = i_upd_pc[31:INDEX_W+2];
   assign upd_entry = table_q[upd_idx];
   assign upd_hit   = upd_entry.valid && (upd_entry.tag == TAG_STORE_W'(upd_tag));

   sat_counter2 u_ctr (
      .ctr  (upd_entry.ctr),
      .up   (i_upd_taken),
      .next (ctr_next)
   );

   // Table write: hits train the counter (and refresh the target on taken);
   // misses allocate only for taken branches, starting weakly taken.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
         end
      end else if (i_upd_valid) begin
         if (upd_hit) begin
            table_q[upd_idx].ctr <= ctr_next;
            if (i_upd_taken) begin
               table_q[upd_idx].target <= i_upd_target;
            end
         end else if (i_upd_taken) begin
            table_q[upd_idx] <= '{valid:  1'b1,
                                  tag:    TAG_STORE_W'(upd_tag),
                                  target: i_upd_target,
                                  ctr:    WT};
         end
      end
   end

   // Statistics counters stick at all-ones instead of wrapping.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_br_count   <= '0;
         o_miss_count <= '0;
      end else begin
         if (i_upd_valid && (o_br_count != '1)) begin
            o_br_count <= o_br_count + 32'd1;
         end
         if (o_mispredict && (o_miss_count != '1)) begin
            o_miss_count <= o_miss_count + 32'd1;
         end
      end
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter INDEX_W, default 5, BTB index width (2**INDEX_W direct-mapped entries).
REQ-002 Parameter TAG_W, default 32-INDEX_W-2, tag width taken from i_pc[31:INDEX_W+2].
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 i_clk  input  1  sole clock, rising-edge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_pc  input  32  fetch-stage PC for lookup.
REQ-007 o_pred_taken  output  1  predicted direction for i_pc.
REQ-008 o_pred_pc  output  32  predicted next PC for i_pc.
REQ-009 i_upd_valid  input  1  a resolved branch/jump is in EX this cycle.
REQ-010 i_upd_pc  input  32  PC of the resolved instruction.
REQ-011 i_upd_taken  input  1  actual direction (from branch comparator plus control logic).
REQ-012 i_upd_target  input  32  actual taken target.
REQ-013 i_upd_pred_taken  input  1  prediction issued for that instruction, carried down the pipe.
REQ-014 i_upd_pred_pc  input  32  predicted next PC issued for that instruction.
REQ-015 o_mispredict  output  1  resolved instruction was mispredicted.
REQ-016 o_redirect_pc  output  32  correct next PC when o_mispredict=1.
REQ-017 o_br_count  output  32  count of accepted updates.
REQ-018 o_miss_count  output  32  count of mispredicts.

Function
REQ-019 Each entry SHALL hold valid(1), tag(TAG_W), target(32), ctr(2).
REQ-020 Lookup SHALL be combinational: idx=i_pc[INDEX_W+1:2]; hit=valid && tag==i_pc[31:INDEX_W+2].
REQ-021 o_pred_taken SHALL be hit && ctr[1]; o_pred_pc SHALL be target when o_pred_taken, else i_pc+4 (32-bit wrap).
REQ-022 o_mispredict SHALL be i_upd_valid && (i_upd_taken!=i_upd_pred_taken || (i_upd_taken && i_upd_target!=i_upd_pred_pc)), combinational.
REQ-023 o_redirect_pc SHALL be i_upd_target when i_upd_taken, else i_upd_pc+4.
REQ-024 On rising edge with i_upd_valid and hit on i_upd_pc: ctr saturating +1 if taken (max 11), -1 if not taken (min 00); target written with i_upd_target when taken.
REQ-025 On update miss with i_upd_taken=1: entry allocated/overwritten with valid=1, tag, target=i_upd_target, ctr=10 (weakly taken).
REQ-026 On update miss with i_upd_taken=0: no table change.
REQ-027 Lookup and update to the same index in one cycle: lookup SHALL return the pre-update contents (no bypass); the new state is visible the next cycle.
REQ-028 o_br_count SHALL increment on every i_upd_valid edge; o_miss_count on every edge with o_mispredict=1; both saturate at 32'hFFFF_FFFF.
REQ-029 Write latency SHALL be exactly one cycle from i_upd_valid to table state change.

Reset
REQ-030 While i_reset=1 (asynchronously): all valid=0, all ctr=01, tags and targets=0, o_br_count=0, o_miss_count=0.
REQ-031 During and after reset, outputs SHALL read o_pred_taken=0, o_pred_pc=i_pc+4; o_mispredict and o_redirect_pc follow REQ-022/023 combinationally.
REQ-032 Reset asserted mid-update SHALL dominate; the concurrent update SHALL be lost.

Structure
REQ-033 Shared package bp_pkg SHALL hold INDEX_W/TAG_W defaults, the counter enum (SNT=00, WNT=01, WT=10, ST=11) and the entry struct typedef.
REQ-034 One sub-module sat_counter2 (2-bit saturating up/down, combinational next-state) SHALL be instantiated for counter update.
REQ-035 Table SHALL be flop-based (async reset required, no SRAM macro).

Verification
REQ-036 Reset, i_pc=32'h0000_0100 -> o_pred_taken=0, o_pred_pc=32'h0000_0104.
REQ-037 Update pc=0x100, taken, target=0x200, pred_taken=0 -> o_mispredict=1, o_redirect_pc=0x200; next cycle lookup 0x100 -> taken, 0x200, ctr=10.
REQ-038 Three more taken updates on 0x100 -> ctr saturates at 11; four not-taken updates -> ctr 00, lookup predicts 0x104.
REQ-039 Alias: allocate 0x100 (INDEX_W=5), then taken update on 0x180 -> lookup 0x100 misses (0x104), 0x180 hits.
REQ-040 Same-cycle lookup/update on 0x100 -> lookup shows old value; next cycle shows new value.
REQ-041 Assert i_reset mid-sequence with i_upd_valid=1 -> table cleared, counters 0, update not applied.
